// File: rtl/serialtx_pkg.sv
// Shared types and constants for the serialtx arbiter slice.
package serialtx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int          FRAME_DEFAULT = 8;
  localparam logic [31:0] WB_TX_ADDR    = 32'h0;

endpackage

// File: rtl/serialtx_arbiter_if.sv
// Wishbone write-only link from the arbiter (master) to the serialtx UART (slave).
interface serialtx_arbiter_if #(
  parameter int FRAME = 8
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [31:0]      addr;
  logic [FRAME-1:0] data_w;
  logic             ack;
  logic             stall;

  modport master (output cyc, stb, we, addr, data_w, input ack, stall);
  modport slave  (input cyc, stb, we, addr, data_w, output ack, stall);
endinterface

// File: rtl/serialtx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serialtx_arbiter.sv
// Round-robin arbiter sharing one serialtx UART between NREQ byte streams,
// with per-packet grant locking and a single outstanding Wishbone write.
module serialtx_arbiter
  import serialtx_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int FRAME        = FRAME_DEFAULT,
  parameter  int LOCK_TIMEOUT = 64,
  localparam int IW           = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*FRAME-1:0] i_req_data,
  input  logic [NREQ-1:0]       i_req_last,
  output logic [NREQ-1:0]       o_req_ready,
  serialtx_arbiter_if.master    m_wb,
  output logic [IW-1:0]         o_grant_id,
  output logic                  o_locked,
  output logic [31:0]           o_bytes_sent
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  state_t            r_state, w_next;
  logic [IW-1:0]     r_rr_ptr, r_grant_id;
  logic              r_locked;
  logic [TW-1:0]     r_timeout;
  logic [FRAME-1:0]  r_data;
  logic [31:0]       r_bytes_sent;

  logic [NREQ-1:0]   w_elig, w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any, w_xfer, w_last, w_done;
  logic [FRAME-1:0]  w_data;

  // While locked only the owner may compete, so the picker lands on it directly.
  assign w_elig = r_locked ? (i_req_valid & (NREQ'(1) << r_grant_id)) : i_req_valid;

  rr_pick #(.N(NREQ)) u_pick (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_xfer = (r_state == IDLE) && w_any;
  assign w_last = i_req_last[w_idx];
  assign w_data = i_req_data[int'(w_idx)*FRAME +: FRAME];
  // An ack alongside an accepted strobe completes the write as well.
  assign w_done = m_wb.ack && ((r_state == WAIT_ACK) || (r_state == REQ && !m_wb.stall));

  // NOTE: sequential state uses non-blocking assignment only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_any) w_next = REQ;
      REQ:      if (!m_wb.stall) w_next = m_wb.ack ? IDLE : WAIT_ACK;
      WAIT_ACK: if (m_wb.ack) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    m_wb.cyc    = (r_state != IDLE);
    m_wb.stb    = (r_state == REQ);
    m_wb.we     = (r_state != IDLE);
    m_wb.addr   = WB_TX_ADDR;
    m_wb.data_w = r_data;
    // Gated by rst_n so ready is low for the whole reset, not just after the first edge.
    o_req_ready = w_gnt & {NREQ{rst_n && (r_state == IDLE)}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_locked     <= 1'b0;
      r_timeout    <= '0;
      r_data       <= '0;
      r_bytes_sent <= '0;
    end else begin
      if (w_xfer) begin
        r_data     <= w_data;
        r_grant_id <= w_idx;
        r_rr_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        r_locked   <= !w_last;
        r_timeout  <= '0;
      end else if (r_state == IDLE && r_locked) begin
        if (r_timeout == TW'(LOCK_TIMEOUT - 1)) begin
          r_locked  <= 1'b0;
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + 1'b1;
        end
      end
      if (w_done) r_bytes_sent <= r_bytes_sent + 32'd1;
    end
  end

  assign o_grant_id   = r_grant_id;
  assign o_locked     = r_locked;
  assign o_bytes_sent = r_bytes_sent;

endmodule
